data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous data memory between two requesters: port 0 (seq_core
//  read/write/address/data port) and port 1 (loader/debug master). A 3-state FSM issues one
//  memory command at a time, pulses a grant, and returns read data with a valid pulse.
//  It sits between the core and the data memory, replacing the core's direct memory hookup.
// PARAMETERS
//  A_SIZE      10  address width, identical on both ports and the memory side
//  D_SIZE      32  data width
//  FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins a tie
// PORTS
//  clk           in   1       single clock, all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  p0_read       in   1       port 0 read request (held until p0_gnt seen)
//  p0_write      in   1       port 0 write request (held until p0_gnt seen)
//  p0_address    in   A_SIZE  port 0 address
//  p0_data_out   in   D_SIZE  port 0 write data
//  p0_data_in    out  D_SIZE  port 0 read data, valid when p0_rvalid=1, held afterwards
//  p0_gnt        out  1       1-cycle pulse: port 0 command issued to memory
//  p0_rvalid     out  1       1-cycle pulse: p0_data_in updated
//  p1_*          --   --      same seven signals for port 1
//  mem_read      out  1       memory read strobe
//  mem_write     out  1       memory write strobe
//  mem_address   out  A_SIZE  memory address
//  mem_data_out  out  D_SIZE  memory write data
//  mem_data_in   in   D_SIZE  memory read data, valid 1 cycle after mem_read
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, all strobes/gnt/rvalid=0, mem_address=0,
//    mem_data_out=0, p*_data_in=0, round-robin pointer = port 0 (last_gnt=1).
//  - States: IDLE, ISSUE, RESP.
//    IDLE: if any port requests (read|write) -> pick winner, register mem_* and winner gnt,
//      -> ISSUE. Otherwise stay IDLE, strobes 0.
//    ISSUE (1 cycle): mem_read/mem_write and pN_gnt high. Write -> IDLE; read -> RESP.
//    RESP (1 cycle): strobes 0, sample mem_data_in into winner's pN_data_in, set its
//      rvalid for the next cycle -> IDLE.
//  - Timing, request first seen in IDLE cycle N: strobe+gnt in N+1; write done at N+1;
//    read data on mem_data_in in N+2; pN_rvalid/pN_data_in in N+3 (state IDLE in N+3).
//    Back-to-back throughput: write 2 cycles, read 3 cycles per transaction.
//  - Requester drops its request in the cycle after gnt; arbiter only samples requests in
//    IDLE, so a request held exactly through the gnt cycle is not re-issued.
//  - Arbitration: one requester -> it wins. Both -> FIXED_PRIO=1: port 0; FIXED_PRIO=0:
//    port opposite to last_gnt. last_gnt updated on every grant.
//  - read and write both high on a port: treated as write; read ignored, no rvalid.
//  - Address and data passed unmodified (no width conversion, no wrap logic).
//  - rvalid only for the port whose read was issued; the other port's data_in unchanged.
//  - rst in any state: abort immediately; pending read dropped, no rvalid, no gnt, pointer
//    returns to reset value. A write strobe already driven in ISSUE is not retracted.
// TESTING
//  1 Reset: rst=1 two cycles with p0_read=1 -> all strobes/gnt/rvalid 0, mem_address=0.
//  2 P0 write addr 5 data 32'hA5A5_0001 -> mem_write=1, mem_address=5 one cycle after
//    request, p0_gnt same cycle; memory[5]=32'hA5A5_0001.
//  3 P0 read addr 5 -> p0_rvalid 3 cycles after request, p0_data_in=32'hA5A5_0001,
//    p1_rvalid stays 0.
//  4 Both ports read continuously (addr 3 / addr 7), FIXED_PRIO=0, mem[i]=i -> grants
//    alternate P1,P0,P1,...; each rvalid returns 3 / 7 for the matching port.
//  5 FIXED_PRIO=1, both request -> port 0 granted every time; port 1 granted only after
//    port 0 drops its request.
//  6 P1 read issued, rst=1 during RESP -> no p1_rvalid, p1_data_in=0, next cycle IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous data memory between the
// core port (port 0) and the loader/debug port (port 1). One command is in
// flight at a time: IDLE picks a winner, ISSUE drives the memory strobe and the
// grant pulse, RESP captures read data and raises that port's rvalid pulse.
module data_mem_arbiter #(
   parameter int A_SIZE     = 10,
   parameter int D_SIZE     = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   // port 0 (core)
   input  logic              p0_read,
   input  logic              p0_write,
   input  logic [A_SIZE-1:0] p0_address,
   input  logic [D_SIZE-1:0] p0_data_out,
   output logic [D_SIZE-1:0] p0_data_in,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   // port 1 (loader / debug)
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic [A_SIZE-1:0] p1_address,
   input  logic [D_SIZE-1:0] p1_data_out,
   output logic [D_SIZE-1:0] p1_data_in,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   // memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [A_SIZE-1:0] mem_address,
   output logic [D_SIZE-1:0] mem_data_out,
   input  logic [D_SIZE-1:0] mem_data_in
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   state_t              state_q;
   logic                last_gnt_q;   // port that received the most recent grant
   logic                owner_q;      // port owning the command in flight
   logic                mem_read_q;
   logic                mem_write_q;
   logic [A_SIZE-1:0]   mem_address_q;
   logic [D_SIZE-1:0]   mem_data_out_q;
   logic                p0_gnt_q;
   logic                p1_gnt_q;
   logic                p0_rvalid_q;
   logic                p1_rvalid_q;
   logic [D_SIZE-1:0]   p0_data_in_q;
   logic [D_SIZE-1:0]   p1_data_in_q;

   // Arbitration inputs: which port would win if IDLE accepted a command now
   logic                p0_req;
   logic                p1_req;
   logic                sel_port;
   logic                sel_write;
   logic [A_SIZE-1:0]   sel_address;
   logic [D_SIZE-1:0]   sel_data;

   // Pick the winner: single requester wins; on a tie, fixed priority or round-robin
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      p0_req    = p0_read | p0_write;
      p1_req    = p1_read | p1_write;
      sel_port  = 1'b0;
      if (p0_req && p1_req) begin
         sel_port = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
      end else if (p1_req) begin
         sel_port = 1'b1;
      end
      // write wins when read and write are both raised on the winning port
      sel_write   = sel_port ? p1_write    : p0_write;
      sel_address = sel_port ? p1_address  : p0_address;
      sel_data    = sel_port ? p1_data_out : p0_data_out;
   end

   // Command FSM with registered memory strobes, grants and read-data returns
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge value of every other register.
      if (rst) begin
         state_q        <= IDLE;
         last_gnt_q     <= 1'b1;
         owner_q        <= 1'b0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_address_q  <= '0;
         mem_data_out_q <= '0;
         p0_gnt_q       <= 1'b0;
         p1_gnt_q       <= 1'b0;
         p0_rvalid_q    <= 1'b0;
         p1_rvalid_q    <= 1'b0;
         p0_data_in_q   <= '0;
         p1_data_in_q   <= '0;
      end else begin
         // strobes and pulses last exactly one cycle unless re-armed below
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         p0_gnt_q    <= 1'b0;
         p1_gnt_q    <= 1'b0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (p0_req || p1_req) begin
                  owner_q        <= sel_port;
                  last_gnt_q     <= sel_port;
                  mem_write_q    <= sel_write;
                  mem_read_q     <= ~sel_write;
                  mem_address_q  <= sel_address;
                  mem_data_out_q <= sel_data;
                  p0_gnt_q       <= ~sel_port;
                  p1_gnt_q       <= sel_port;
                  state_q        <= ISSUE;
               end
            end
            ISSUE: begin
               // a write completes with its strobe; a read waits one cycle for data
               state_q <= mem_write_q ? IDLE : RESP;
            end
            RESP: begin
               if (owner_q) begin
                  p1_data_in_q <= mem_data_in;
                  p1_rvalid_q  <= 1'b1;
               end else begin
                  p0_data_in_q <= mem_data_in;
                  p0_rvalid_q  <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_address  = mem_address_q;
   assign mem_data_out = mem_data_out_q;
   assign p0_gnt       = p0_gnt_q;
   assign p1_gnt       = p1_gnt_q;
   assign p0_rvalid    = p0_rvalid_q;
   assign p1_rvalid    = p1_rvalid_q;
   assign p0_data_in   = p0_data_in_q;
   assign p1_data_in   = p1_data_in_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic from two handshaking requesters. A transaction-level model
// (time-stamped schedule plus a shadow memory) predicts every output each cycle.
module tb_data_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // round-robin instance
   logic          p0_read = 1'b0, p0_write = 1'b0;
   logic [AW-1:0] p0_address = '0;
   logic [DW-1:0] p0_data_out = '0;
   logic [DW-1:0] p0_data_in;
   logic          p0_gnt, p0_rvalid;
   logic          p1_read = 1'b0, p1_write = 1'b0;
   logic [AW-1:0] p1_address = '0;
   logic [DW-1:0] p1_data_out = '0;
   logic [DW-1:0] p1_data_in;
   logic          p1_gnt, p1_rvalid;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_out;
   logic [DW-1:0] mem_data_in;

   // fixed-priority instance
   logic          f0_read = 1'b0, f0_write = 1'b0;
   logic [AW-1:0] f0_address = '0;
   logic [DW-1:0] f0_data_out = '0;
   logic [DW-1:0] f0_data_in;
   logic          f0_gnt, f0_rvalid;
   logic          f1_read = 1'b0, f1_write = 1'b0;
   logic [AW-1:0] f1_address = '0;
   logic [DW-1:0] f1_data_out = '0;
   logic [DW-1:0] f1_data_in;
   logic          f1_gnt, f1_rvalid;
   logic          fmem_read, fmem_write;
   logic [AW-1:0] fmem_address;
   logic [DW-1:0] fmem_data_out;
   logic [DW-1:0] fmem_data_in = '0;

   int total = 0;
   int bad   = 0;

   data_mem_arbiter #(.A_SIZE(AW), .D_SIZE(DW), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .rst(rst),
      .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
      .p0_data_out(p0_data_out), .p0_data_in(p0_data_in), .p0_gnt(p0_gnt),
      .p0_rvalid(p0_rvalid),
      .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
      .p1_data_out(p1_data_out), .p1_data_in(p1_data_in), .p1_gnt(p1_gnt),
      .p1_rvalid(p1_rvalid),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
   );

   data_mem_arbiter #(.A_SIZE(AW), .D_SIZE(DW), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .rst(rst),
      .p0_read(f0_read), .p0_write(f0_write), .p0_address(f0_address),
      .p0_data_out(f0_data_out), .p0_data_in(f0_data_in), .p0_gnt(f0_gnt),
      .p0_rvalid(f0_rvalid),
      .p1_read(f1_read), .p1_write(f1_write), .p1_address(f1_address),
      .p1_data_out(f1_data_out), .p1_data_in(f1_data_in), .p1_gnt(f1_gnt),
      .p1_rvalid(f1_rvalid),
      .mem_read(fmem_read), .mem_write(fmem_write), .mem_address(fmem_address),
      .mem_data_out(fmem_data_out), .mem_data_in(fmem_data_in)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous single-port memory: write on strobe, read data one cycle later
   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] rd_q = '0;
   assign mem_data_in = rd_q;
   always @(posedge clk) begin
      if (mem_write) mem[mem_address] <= mem_data_out;
      if (mem_read)  rd_q <= mem[mem_address];
   end

   // Transaction-level reference model of the round-robin instance
   logic [DW-1:0] model_mem [0:1023];
   bit            cmp_en = 1'b0;
   int unsigned   edge_n = 0, ready_at = 0, rsp_at = 0;
   bit            rsp_pend = 1'b0, rsp_port = 1'b0, last_port = 1'b1;
   logic [DW-1:0] rsp_data = '0;
   logic          e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_rv0 = 1'b0, e_rv1 = 1'b0;
   logic          e_mrd = 1'b0, e_mwr = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_mdo = '0, e_din0 = '0, e_din1 = '0;

   always @(posedge clk) begin : model
      bit            r0, r1, port, wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      edge_n++;
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
      e_mrd  = 1'b0; e_mwr  = 1'b0;
      if (rst) begin
         e_addr = '0; e_mdo = '0; e_din0 = '0; e_din1 = '0;
         last_port = 1'b1; rsp_pend = 1'b0; ready_at = edge_n + 1;
      end else begin
         if (rsp_pend && rsp_at == edge_n) begin
            if (rsp_port) begin e_rv1 = 1'b1; e_din1 = rsp_data; end
            else          begin e_rv0 = 1'b1; e_din0 = rsp_data; end
            rsp_pend = 1'b0;
         end
         r0 = p0_read | p0_write;
         r1 = p1_read | p1_write;
         if (edge_n >= ready_at && (r0 || r1)) begin
            port = (r0 && r1) ? !last_port : r1;
            wr   = port ? p1_write : p0_write;
            a    = port ? p1_address : p0_address;
            d    = port ? p1_data_out : p0_data_out;
            if (port) e_gnt1 = 1'b1; else e_gnt0 = 1'b1;
            e_mwr = wr; e_mrd = !wr; e_addr = a; e_mdo = d;
            if (wr) begin
               model_mem[a] = d;
               ready_at = edge_n + 2;
            end else begin
               rsp_pend = 1'b1; rsp_port = port; rsp_at = edge_n + 2;
               rsp_data = model_mem[a];
               ready_at = edge_n + 3;
            end
            last_port = port;
         end
      end
   end

   // Compare every DUT output against the model in the middle of each cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         check("p0_gnt", p0_gnt, e_gnt0);
         check("p1_gnt", p1_gnt, e_gnt1);
         check("p0_rvalid", p0_rvalid, e_rv0);
         check("p1_rvalid", p1_rvalid, e_rv1);
         check("p0_data_in", p0_data_in, e_din0);
         check("p1_data_in", p1_data_in, e_din1);
         check("mem_read", mem_read, e_mrd);
         check("mem_write", mem_write, e_mwr);
         check("mem_address", mem_address, e_addr);
         check("mem_data_out", mem_data_out, e_mdo);
      end
   end

   // Randomized requesters: raise a request, hold it until gnt, drop it the cycle after
   bit rand_en = 1'b0;
   bit seen0 = 1'b0, seen1 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
   always @(negedge clk) begin
      seen0 = p0_gnt;
      seen1 = p1_gnt;
   end

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         if (hold0) begin
            if (seen0) begin p0_read = 1'b0; p0_write = 1'b0; hold0 = 1'b0; end
         end else if ($urandom_range(0, 2) == 0) begin
            p0_address  = AW'($urandom_range(0, 15));
            p0_data_out = $urandom;
            case ($urandom_range(0, 7))
               0:       begin p0_read = 1'b1; p0_write = 1'b1; end
               1, 2, 3: begin p0_read = 1'b1; p0_write = 1'b0; end
               default: begin p0_read = 1'b0; p0_write = 1'b1; end
            endcase
            hold0 = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         if (hold1) begin
            if (seen1) begin p1_read = 1'b0; p1_write = 1'b0; hold1 = 1'b0; end
         end else if ($urandom_range(0, 2) == 0) begin
            p1_address  = AW'($urandom_range(0, 15));
            p1_data_out = $urandom;
            case ($urandom_range(0, 7))
               0:       begin p1_read = 1'b1; p1_write = 1'b1; end
               1, 2, 3: begin p1_read = 1'b1; p1_write = 1'b0; end
               default: begin p1_read = 1'b0; p1_write = 1'b1; end
            endcase
            hold1 = 1'b1;
         end
      end
   end

   int ph0, ph1, rv0_cnt, rv1_cnt, n0, n1;
   int gq[$];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]       = DW'(i);
         model_mem[i] = DW'(i);
      end

      // reset held two cycles with a read pending on port 0
      rst = 1'b1; p0_read = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_gnt", {p0_gnt, p1_gnt}, 0);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);

      // port 0 write to address 5
      rst = 1'b0; p0_read = 1'b0;
      p0_write = 1'b1; p0_address = 10'd5; p0_data_out = 32'hA5A5_0001;
      tick();
      check("wr_mem_write", mem_write, 1);
      check("wr_mem_read", mem_read, 0);
      check("wr_mem_address", mem_address, 5);
      check("wr_mem_data_out", mem_data_out, 32'hA5A5_0001);
      check("wr_p0_gnt", p0_gnt, 1);
      check("wr_p1_gnt", p1_gnt, 0);
      tick();
      p0_write = 1'b0;
      check("wr_mem5", mem[5], 32'hA5A5_0001);
      tick();

      // port 0 read back from address 5: rvalid three cycles after the request
      p0_read = 1'b1; p0_address = 10'd5;
      tick();
      check("rd_p0_gnt", p0_gnt, 1);
      check("rd_mem_read", mem_read, 1);
      tick();
      p0_read = 1'b0;
      check("rd_early_rvalid", p0_rvalid, 0);
      tick();
      check("rd_p0_rvalid", p0_rvalid, 1);
      check("rd_p0_data", p0_data_in, 32'hA5A5_0001);
      check("rd_p1_rvalid", p1_rvalid, 0);
      tick();
      check("rd_rvalid_pulse", p0_rvalid, 0);
      check("rd_data_held", p0_data_in, 32'hA5A5_0001);

      // both ports read continuously: grants alternate starting with port 1
      p0_address = 10'd3; p1_address = 10'd7; p0_read = 1'b1; p1_read = 1'b1;
      ph0 = 0; ph1 = 0; rv0_cnt = 0; rv1_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (ph0 == 1) begin p0_read = 1'b0; ph0 = 2; end
         else if (ph0 == 2) begin p0_read = 1'b1; ph0 = 0; end
         if (ph1 == 1) begin p1_read = 1'b0; ph1 = 2; end
         else if (ph1 == 2) begin p1_read = 1'b1; ph1 = 0; end
         if (p0_gnt) begin gq.push_back(0); ph0 = 1; end
         if (p1_gnt) begin gq.push_back(1); ph1 = 1; end
         if (p0_rvalid) begin rv0_cnt++; check("rr_p0_data", p0_data_in, 3); end
         if (p1_rvalid) begin rv1_cnt++; check("rr_p1_data", p1_data_in, 7); end
      end
      p0_read = 1'b0; p1_read = 1'b0;
      check("rr_grant_count", gq.size(), 5);
      for (int k = 0; k < 5 && k < gq.size(); k++)
         check($sformatf("rr_grant_%0d", k), gq[k], (k % 2 == 0) ? 1 : 0);
      check("rr_p0_rvalids", rv0_cnt, 2);
      check("rr_p1_rvalids", rv1_cnt, 2);
      repeat (3) tick();

      // port 1 read aborted by reset during the response cycle
      p1_read = 1'b1; p1_address = 10'd9;
      tick();
      check("abort_p1_gnt", p1_gnt, 1);
      tick();
      p1_read = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_p1_rvalid", p1_rvalid, 0);
      check("abort_p1_data", p1_data_in, 0);
      check("abort_p0_data", p0_data_in, 0);
      // back in IDLE with the pointer reset: a tie goes to port 0
      p0_read = 1'b1; p1_read = 1'b1; p0_address = 10'd1; p1_address = 10'd2;
      tick();
      check("post_rst_p0_gnt", p0_gnt, 1);
      check("post_rst_p1_gnt", p1_gnt, 0);
      check("post_rst_addr", mem_address, 1);
      check("abort_no_late_rvalid", p1_rvalid, 0);
      tick();
      p0_read = 1'b0;
      tick();
      check("post_rst_p0_rvalid", p0_rvalid, 1);
      check("post_rst_p0_data", p0_data_in, 1);
      tick();
      check("post_rst_p1_gnt2", p1_gnt, 1);
      check("post_rst_addr2", mem_address, 2);
      tick();
      p1_read = 1'b0;
      tick();
      check("post_rst_p1_rvalid", p1_rvalid, 1);
      check("post_rst_p1_data", p1_data_in, 2);
      tick();

      // fixed priority: port 0 holding its write starves port 1 until it lets go
      f0_write = 1'b1; f1_write = 1'b1; f0_address = 10'd11; f1_address = 10'd22;
      f0_data_out = 32'h1111_0000; f1_data_out = 32'h2222_0000;
      n0 = 0; n1 = 0;
      repeat (8) begin
         tick();
         if (f0_gnt) n0++;
         if (f1_gnt) n1++;
      end
      check("fix_p0_grants", n0, 4);
      check("fix_p1_grants", n1, 0);
      f0_write = 1'b0;
      tick();
      check("fix_p1_gnt", f1_gnt, 1);
      check("fix_p0_gnt", f0_gnt, 0);
      check("fix_addr", fmem_address, 22);
      check("fix_wdata", fmem_data_out, 32'h2222_0000);
      tick();
      f1_write = 1'b0;
      tick();

      // randomized traffic with occasional resets
      rand_en = 1'b1;
      repeat (3000) begin
         tick();
         rst = ($urandom_range(0, 149) == 0);
      end
      rand_en = 1'b0;
      tick();
      rst = 1'b0;
      p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
